// File: rtl/t07_mem_handler.sv
// ---------------------------------------------------------------------------
// t07_mem_handler
//
// Memory handler for the team 07 core. It accepts a decoded load/store from
// the control unit and ALU and turns it into one word-wide bus transaction.
// It holds the PC frozen until the access finishes, then returns the
// lane-extracted, sign/zero-extended load value to the write-back mux.
//
// Parameters:
//   TIMEOUT     maximum REQ cycles without busAck before the access is
//               abandoned (1..255)
//
// Ports:
//   clk         system clock, rising edge
//   nrst        asynchronous active-low reset
//   memOp       0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw
//   memRead     load strobe from the control unit
//   memWrite    store strobe from the control unit
//   addr        effective byte address
//   storeData   rs2 value for stores
//   regData     registered load result for the write-back mux
//   freeze      stalls PC / instruction advance while high
//   misaligned  one-cycle pulse when a request is rejected for alignment
//   busTimeout  one-cycle pulse when an access is abandoned
//   busAddr     word-aligned bus address
//   busWData    lane-replicated store data
//   busSel      byte enables
//   busRead     read request, held until ack
//   busWrite    write request, held until ack
//   busRData    read data, valid with busAck
//   busAck      one-cycle completion from the bus
// ---------------------------------------------------------------------------
module t07_mem_handler #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  memOp,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic [31:0] regData,
  output logic        freeze,
  output logic        misaligned,
  output logic        busTimeout,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [3:0]  busSel,
  output logic        busRead,
  output logic        busWrite,
  input  logic [31:0] busRData,
  input  logic        busAck
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Counter value on the last REQ cycle before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [7:0]  cnt;
  logic        timed_out_q;

  logic        is_load_op;
  logic        is_store_op;
  logic        req_valid;
  logic        aligned;
  logic        accept;
  logic        op_q_load;
  logic        op_q_store;

  // Byte enables for an access of the given op at the given byte lane.
  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] lane);
    logic [3:0] s;
    case (op)
      4'd1, 4'd4, 4'd6: s = 4'b0001 << lane;
      4'd2, 4'd5, 4'd7: s = lane[1] ? 4'b1100 : 4'b0011;
      default:          s = 4'b1111;
    endcase
    return s;
  endfunction

  // Store data replicated across every lane the access width can hit.
  function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] data);
    logic [31:0] w;
    case (op)
      4'd6:    w = {4{data[7:0]}};
      4'd7:    w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Pull the addressed byte/half out of the bus word and extend it.
  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = $signed(word[{lane, 3'b000} +: 8]);
    h = $signed(lane[1] ? word[31:16] : word[15:0]);
    case (op)
      4'd1:    r = {{24{b[7]}}, b};
      4'd4:    r = {24'd0, b};
      4'd2:    r = {{16{h[15]}}, h};
      4'd5:    r = {16'd0, h};
      4'd3:    r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    is_load_op  = (memOp >= 4'd1) && (memOp <= 4'd5);
    is_store_op = (memOp >= 4'd6) && (memOp <= 4'd8);
    req_valid   = (memRead && !memWrite && is_load_op) ||
                  (memWrite && !memRead && is_store_op);
    case (memOp)
      4'd2, 4'd5, 4'd7: aligned = !addr[0];
      4'd3, 4'd8:       aligned = (addr[1:0] == 2'b00);
      default:          aligned = 1'b1;
    endcase
    accept     = (state == IDLE) && req_valid && aligned;
    misaligned = (state == IDLE) && req_valid && !aligned;
    freeze     = accept || (state == REQ);

    op_q_load  = (op_q >= 4'd1) && (op_q <= 4'd5);
    op_q_store = (op_q >= 4'd6) && (op_q <= 4'd8);
    busRead    = (state == REQ) && op_q_load;
    busWrite   = (state == REQ) && op_q_store;
    busTimeout = (state == DONE) && timed_out_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ:  if (busAck || (cnt == CNT_LAST)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      op_q        <= 4'd0;
      lane_q      <= 2'd0;
      cnt         <= 8'd0;
      timed_out_q <= 1'b0;
      regData     <= 32'd0;
      busAddr     <= 32'd0;
      busWData    <= 32'd0;
      busSel      <= 4'd0;
    end else begin
      state <= state_next;
      case (state)
        // Accept: capture everything the bus needs so it stays stable in REQ.
        IDLE: begin
          if (accept) begin
            op_q        <= memOp;
            lane_q      <= addr[1:0];
            busAddr     <= {addr[31:2], 2'b00};
            busWData    <= lane_wdata(memOp, storeData);
            busSel      <= lane_sel(memOp, addr[1:0]);
            cnt         <= 8'd0;
            timed_out_q <= 1'b0;
          end
        end
        // Bus wait: ack takes priority over the timeout on the same cycle.
        REQ: begin
          if (busAck) begin
            if (op_q_load) regData <= load_extract(op_q, lane_q, busRData);
          end else if (cnt == CNT_LAST) begin
            timed_out_q <= 1'b1;
            if (op_q_load) regData <= 32'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // Completion: single cycle, inputs ignored.
        DONE: timed_out_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
